// File: rtl/pll_lock_sequencer_pkg.sv
// rtl/pll_lock_sequencer_pkg.sv - state encodings and default constants for the PLL lock sequencer
package pll_lock_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  localparam int DEF_RST_CYC      = 16;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int DEF_STABLE_CYC   = 256;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_CW           = 12;

  function automatic logic state_is_busy(input state_e s);
    return (s == S_RESET) || (s == S_WAIT) || (s == S_STABLE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock wait with timeout/retry, stability window, ready
// Defining PLLSEQ_LOSS_CNT_EN adds the saturating lock_loss_cnt output.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int RST_CYC      = DEF_RST_CYC,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYC   = DEF_STABLE_CYC,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int CW           = DEF_CW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pllrst,
  output logic       ready,
  output logic       busy,
  output logic       fail,
  output logic [3:0] retry_cnt
`ifdef PLLSEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYC);
  localparam logic [CW-1:0] WAIT_LOAD   = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] STABLE_LOAD = CW'(STABLE_CYC - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d, retry_inc;
  logic          pllrst_q, pllrst_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          fail_q, fail_d;
  logic          lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    retry_inc = retry_q + 4'd1;
    if (restart) begin
      state_d = S_RESET;
      cnt_d   = RST_LOAD;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        // RESET/WAIT leave on the edge that would take the counter to 0, so they last exactly N edges
        S_RESET: begin
          if (cnt_q == CNT_ONE) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            state_d = S_STABLE;
            cnt_d   = STABLE_LOAD;
          end else if (cnt_q == CNT_ONE) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET;
            cnt_d   = (retry_inc == RETRY_MAX) ? '0 : RST_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = S_LOCKED;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_LOCKED: begin
          if (!lock_s) begin
            state_d = S_RESET;
            cnt_d   = RST_LOAD;
            retry_d = 4'd0;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_RESET;
          cnt_d   = RST_LOAD;
          retry_d = 4'd0;
        end
      endcase
    end
    pllrst_d = (state_d == S_RESET);
    ready_d  = (state_d == S_LOCKED);
    busy_d   = state_is_busy(state_d);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RESET;
      cnt_q    <= RST_LOAD;
      retry_q  <= 4'd0;
      pllrst_q <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      pllrst_q <= pllrst_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      fail_q   <= fail_d;
    end
  end

  assign pllrst    = pllrst_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

`ifdef PLLSEQ_LOSS_CNT_EN
  // Only genuine lock loss counts; a restart on the same edge wins and is not a loss.
  logic       lock_lost;
  logic [7:0] loss_q, loss_d;

  assign lock_lost = (state_q == S_LOCKED) && !lock_s && !restart;

  always_comb begin
    loss_d = loss_q;
    if (lock_lost && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loss_q <= 8'd0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_cnt = loss_q;
`endif
endmodule
